// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared definitions for the common-data-bus (CDB) arbiter and
//               the Tomasulo units that broadcast through it.
//               CDB tag width, the "no tag" value, unit port indices,
//               reservation-station tag values and a wrap-around index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Bus geometry used by the core; the arbiter is still parameterised.
  localparam int c_CDB_TAG_W  = 5;
  localparam int c_CDB_DATA_W = 32;
  localparam int c_CDB_NREQ   = 4;

  // Tag 0 means "no producer pending / value ready" and is never broadcast.
  localparam logic [c_CDB_TAG_W-1:0] c_NO_TAG = '0;

  // Arbiter port assignment of each functional unit.
  localparam int c_CDB_ALU = 0;
  localparam int c_CDB_MUL = 1;
  localparam int c_CDB_MEM = 2;
  localparam int c_CDB_BR  = 3;

  // Reservation-station tags shared by every unit and the register-status table.
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_MEM0 = 5'd1;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_MEM1 = 5'd2;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_ALU0 = 5'd3;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_ALU1 = 5'd4;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_ALU2 = 5'd5;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_MUL0 = 5'd6;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_MUL1 = 5'd7;
  localparam logic [c_CDB_TAG_W-1:0] c_TAG_BR0  = 5'd8;

  // (a + b) mod n for operands already below n; avoids a real divider.
  function automatic int cdb_wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    while (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_rr_pick
// Description : Round-robin picker. Rotates the request vector so that index
//               ptr lands at position 0, priority-encodes the lowest set bit,
//               then rotates the winner back to an absolute index.
//               Outputs a one-hot grant, the grant index and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_vld
);

  logic [NREQ-1:0] w_rot;
  logic [PW-1:0]   w_rot_idx;
  logic            w_found;

  // Rotate: position j of w_rot is absolute request (ptr + j) mod NREQ.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_rot[j] = req[PW'(cdb_wrap_add(int'(ptr), j, NREQ))];
    end
  end

  // Priority-encode the rotated vector: lowest position wins.
  always_comb begin
    w_found   = 1'b0;
    w_rot_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found   = 1'b1;
        w_rot_idx = PW'(j);
      end
    end
  end

  // Unrotate back to the absolute index and build the one-hot grant.
  always_comb begin
    grant     = '0;
    grant_vld = w_found;
    grant_idx = PW'(cdb_wrap_add(int'(ptr), int'(w_rot_idx), NREQ));
    if (w_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common-data-bus master for the Tomasulo core. Grants one
//               broadcast request per cycle (combinational one-hot ack) and
//               drives the registered BCEN/BClabel/BCdata broadcast one cycle
//               later. A granted request carrying tag 0 is acked but not
//               broadcast and sets the sticky err_tag0 flag.
//               Build option CDB_FIXED_PRIO_EN: fixed priority (lowest index
//               wins) instead of round-robin; the round-robin pointer is removed.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LW   = 5,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] label_in,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]  ack,
  output logic             BCEN,
  output logic [LW-1:0]    BClabel,
  output logic [DW-1:0]    BCdata,
  output logic             err_tag0
);

  logic [NREQ-1:0] w_grant;
  logic            w_grant_vld;

`ifdef CDB_FIXED_PRIO_EN

  // Fixed priority: the lowest requesting index always wins.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && req[i]) begin
        w_grant[i]  = 1'b1;
        w_grant_vld = 1'b1;
      end
    end
  end

`else

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] w_grant_idx;
  logic [PW-1:0] rr_ptr_d;
  logic [PW-1:0] rr_ptr_q;

  cdb_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_vld (w_grant_vld)
  );

  // Search starts just past the last winner; hold the pointer when idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_grant_vld) begin
      rr_ptr_d = PW'(cdb_wrap_add(int'(w_grant_idx), 1, NREQ));
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`endif

  assign ack = w_grant;

  logic [LW-1:0] w_sel_label;
  logic [DW-1:0] w_sel_data;

  // One-hot AND-OR mux of the winner's label and data.
  always_comb begin
    w_sel_label = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_label = w_sel_label | label_in[i*LW +: LW];
        w_sel_data  = w_sel_data  | data_in[i*DW +: DW];
      end
    end
  end

  logic          bcen_d;
  logic          bcen_q;
  logic [LW-1:0] bclabel_d;
  logic [LW-1:0] bclabel_q;
  logic [DW-1:0] bcdata_d;
  logic [DW-1:0] bcdata_q;
  logic          err_tag0_d;
  logic          err_tag0_q;

  // Broadcast next-state: tag 0 frees the unit but is flagged, not broadcast;
  // label/data hold their last values whenever nothing is broadcast.
  always_comb begin
    bcen_d     = 1'b0;
    bclabel_d  = bclabel_q;
    bcdata_d   = bcdata_q;
    err_tag0_d = err_tag0_q;
    if (w_grant_vld) begin
      if (w_sel_label == LW'(c_NO_TAG)) begin
        err_tag0_d = 1'b1;
      end else begin
        bcen_d    = 1'b1;
        bclabel_d = w_sel_label;
        bcdata_d  = w_sel_data;
      end
    end
  end

  // Broadcast and error registers; reset discards any grant in flight.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bcen_q     <= 1'b0;
      bclabel_q  <= '0;
      bcdata_q   <= '0;
      err_tag0_q <= 1'b0;
    end else begin
      bcen_q     <= bcen_d;
      bclabel_q  <= bclabel_d;
      bcdata_q   <= bcdata_d;
      err_tag0_q <= err_tag0_d;
    end
  end

  assign BCEN     = bcen_q;
  assign BClabel  = bclabel_q;
  assign BCdata   = bcdata_q;
  assign err_tag0 = err_tag0_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter (NREQ=4, LW=5,
//               DW=32). Inputs change 1 ns after posedge; outputs are checked
//               away from the clock edge against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int NREQ = 4;
  localparam int LW   = 5;
  localparam int DW   = 32;

  logic                 clk;
  logic                 nRST;
  logic [NREQ-1:0]      req;
  logic [NREQ*LW-1:0]   label_in;
  logic [NREQ*DW-1:0]   data_in;
  logic [NREQ-1:0]      ack;
  logic                 BCEN;
  logic [LW-1:0]        BClabel;
  logic [DW-1:0]        BCdata;
  logic                 err_tag0;

  int n_total;
  int n_bad;

  cdb_arbiter #(
    .NREQ (NREQ),
    .LW   (LW),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .req      (req),
    .label_in (label_in),
    .data_in  (data_in),
    .ack      (ack),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata),
    .err_tag0 (err_tag0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
    label_in[i*LW +: LW] = l;
    data_in[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  logic [NREQ-1:0] exp_ack [4];
  logic [LW-1:0]   exp_lab [4];

  initial begin
    n_total  = 0;
    n_bad    = 0;
    nRST     = 1'b1;
    req      = '0;
    label_in = '0;
    data_in  = '0;
    #1;
    nRST = 1'b0;
    tick();
    tick();

    // Reset state
    chk_eq("rst_bcen", 32'(BCEN), 32'd0);
    chk_eq("rst_label", 32'(BClabel), 32'd0);
    chk_eq("rst_data", BCdata, 32'd0);
    chk_eq("rst_err", 32'(err_tag0), 32'd0);
    chk_eq("rst_ack", 32'(ack), 32'd0);
    nRST = 1'b1;
    tick();

    // Single request from unit 2
    set_unit(2, 5'd7, 32'hDEADBEEF);
    req = 4'b0100;
    #1;
    chk_eq("single_ack", 32'(ack), 32'h4);
    tick();
    req = '0;
    chk_eq("single_bcen", 32'(BCEN), 32'd1);
    chk_eq("single_label", 32'(BClabel), 32'd7);
    chk_eq("single_data", BCdata, 32'hDEADBEEF);
    #1;
    chk_eq("single_ack_idle", 32'(ack), 32'd0);
    tick();
    chk_eq("single_bcen_off", 32'(BCEN), 32'd0);
    chk_eq("single_label_hold", 32'(BClabel), 32'd7);

`ifdef CDB_FIXED_PRIO_EN
    // Fixed priority: unit 1 keeps requesting and unit 3 starves
    do_reset();
    set_unit(1, 5'd8, 32'h0000_0808);
    set_unit(3, 5'd15, 32'h0000_0F0F);
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_eq("fixed_ack", 32'(ack), 32'h2);
      tick();
      chk_eq("fixed_bcen", 32'(BCEN), 32'd1);
      chk_eq("fixed_label", 32'(BClabel), 32'd8);
    end
    req = '0;
    tick();
`else
    // Contention from reset: grant order 0,1,2,3, back-to-back broadcasts
    do_reset();
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100; exp_ack[3] = 4'b1000;
    exp_lab[0] = 5'd1;    exp_lab[1] = 5'd2;    exp_lab[2] = 5'd3;    exp_lab[3] = 5'd4;
    for (int i = 0; i < NREQ; i++) begin
      set_unit(i, LW'(i + 1), 32'(32'h100 + i));
    end
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_eq($sformatf("rr_ack%0d", k), 32'(ack), 32'(exp_ack[k]));
      tick();
      req = req & ~exp_ack[k];
      chk_eq($sformatf("rr_bcen%0d", k), 32'(BCEN), 32'd1);
      chk_eq($sformatf("rr_label%0d", k), 32'(BClabel), 32'(exp_lab[k]));
    end
    #1;
    chk_eq("rr_ack_idle", 32'(ack), 32'd0);
    tick();
    chk_eq("rr_bcen_off", 32'(BCEN), 32'd0);

    // Wrap: after a grant to unit 2 the pointer is 3, so 3 beats 0
    set_unit(2, 5'd5, 32'h0000_0505);
    req = 4'b0100;
    #1;
    chk_eq("wrap_pre_ack", 32'(ack), 32'h4);
    tick();
    req = '0;
    set_unit(0, 5'd10, 32'hA0A0_A0A0);
    set_unit(3, 5'd11, 32'hA3A3_A3A3);
    req = 4'b1001;
    #1;
    chk_eq("wrap_ack3", 32'(ack), 32'h8);
    tick();
    req = 4'b0001;
    chk_eq("wrap_label3", 32'(BClabel), 32'd11);
    chk_eq("wrap_data3", BCdata, 32'hA3A3_A3A3);
    #1;
    chk_eq("wrap_ack0", 32'(ack), 32'h1);
    tick();
    req = '0;
    chk_eq("wrap_bcen0", 32'(BCEN), 32'd1);
    chk_eq("wrap_label0", 32'(BClabel), 32'd10);
    chk_eq("wrap_data0", BCdata, 32'hA0A0_A0A0);
`endif

    // Tag zero: acked, not broadcast, sticky error
    set_unit(0, 5'd0, 32'h0000_0055);
    req = 4'b0001;
    #1;
    chk_eq("tag0_ack", 32'(ack), 32'h1);
    tick();
    req = '0;
    chk_eq("tag0_bcen", 32'(BCEN), 32'd0);
    chk_eq("tag0_err", 32'(err_tag0), 32'd1);
    tick();
    chk_eq("tag0_err_sticky", 32'(err_tag0), 32'd1);
    set_unit(1, 5'd6, 32'h0000_0066);
    req = 4'b0010;
    #1;
    chk_eq("tag0_next_ack", 32'(ack), 32'h2);
    tick();
    req = '0;
    chk_eq("tag0_next_bcen", 32'(BCEN), 32'd1);
    chk_eq("tag0_next_label", 32'(BClabel), 32'd6);
    chk_eq("tag0_err_kept", 32'(err_tag0), 32'd1);

    // Reset mid-flight: broadcast of label 9 is wiped immediately
    set_unit(1, 5'd9, 32'h0000_0099);
    req = 4'b0010;
    #1;
    chk_eq("midrst_ack", 32'(ack), 32'h2);
    tick();
    req = '0;
    chk_eq("midrst_bcen_pre", 32'(BCEN), 32'd1);
    chk_eq("midrst_label_pre", 32'(BClabel), 32'd9);
    #2;
    nRST = 1'b0;
    #1;
    chk_eq("midrst_bcen", 32'(BCEN), 32'd0);
    chk_eq("midrst_label", 32'(BClabel), 32'd0);
    chk_eq("midrst_data", BCdata, 32'd0);
    chk_eq("midrst_err", 32'(err_tag0), 32'd0);
    #1;
    nRST = 1'b1;
    // Pointer back at 0: unit 1 must beat unit 2
    set_unit(1, 5'd12, 32'h0000_0C0C);
    set_unit(2, 5'd13, 32'h0000_0D0D);
    req = 4'b0110;
    #1;
    chk_eq("postrst_ack1", 32'(ack), 32'h2);
    tick();
    req = 4'b0100;
    chk_eq("postrst_label1", 32'(BClabel), 32'd12);
    #1;
    chk_eq("postrst_ack2", 32'(ack), 32'h4);
    tick();
    req = '0;
    chk_eq("postrst_label2", 32'(BClabel), 32'd13);
    set_unit(0, 5'd14, 32'h0000_0E0E);
    req = 4'b0001;
    #1;
    chk_eq("postrst_ack0", 32'(ack), 32'h1);
    tick();
    req = '0;
    chk_eq("postrst_bcen0", 32'(BCEN), 32'd1);
    chk_eq("postrst_label0", 32'(BClabel), 32'd14);
    chk_eq("postrst_data0", BCdata, 32'h0000_0E0E);
    tick();
    chk_eq("final_bcen_off", 32'(BCEN), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
